// File: rtl/mips_avalon_arbiter.sv
// Two-master Avalon-MM arbiter (M0 data, M1 ifetch) with stall watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is M0 priority.
module mips_avalon_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic [3:0]  m1_byteenable,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] s_address,
  output logic [3:0]  s_byteenable,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  localparam logic [9:0]  STALL_MAX = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  state_t     state;
  state_t     state_nxt;
  logic [9:0] stall_cnt;
  logic       last_grant;

  logic m0_req;
  logic m1_req;
  logic gnt0;
  logic gnt1;
  logic g_req;
  logic tie_m1;
  logic timeout_hit;
  logic leave;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;
  assign gnt0   = (state == GRANT0);
  assign gnt1   = (state == GRANT1);
  assign g_req  = (gnt0 & m0_req) | (gnt1 & m1_req);

  // Round-robin hands a tie to whoever was not served last.
  assign tie_m1 = RR_EN & ~last_grant;

  assign timeout_hit = g_req & s_waitrequest
                     & (stall_cnt == STALL_MAX);

  // Grant ends on completion, master abort or watchdog abort.
  assign leave = (gnt0 | gnt1)
               & (~g_req | ~s_waitrequest | timeout_hit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_nxt = tie_m1 ? GRANT1 : GRANT0;
        end else if (m0_req) begin
          state_nxt = GRANT0;
        end else if (m1_req) begin
          state_nxt = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (leave) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt   <= '0;
      bus_timeout <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      if (state == IDLE || leave) begin
        stall_cnt <= '0;
      end else if (s_waitrequest) begin
        stall_cnt <= stall_cnt + 10'd1;
      end
      if (timeout_hit) begin
        bus_timeout <= 1'b1;
      end
      if (leave) begin
        last_grant <= gnt1;
      end
    end
  end

  always_comb begin
    s_address      = '0;
    s_byteenable   = '0;
    s_writedata    = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    unique case (1'b1)
      gnt0: begin
        s_address      = m0_address;
        s_byteenable   = m0_byteenable;
        s_writedata    = m0_writedata;
        s_read         = m0_read & ~m0_write;
        s_write        = m0_write;
        m0_waitrequest = s_waitrequest;
        m0_readdata    = s_readdata;
        if (timeout_hit) begin
          m0_waitrequest = 1'b0;
          m0_readdata    = ABORT_DATA;
        end
      end
      gnt1: begin
        s_address      = m1_address;
        s_byteenable   = m1_byteenable;
        s_writedata    = m1_writedata;
        s_read         = m1_read & ~m1_write;
        s_write        = m1_write;
        m1_waitrequest = s_waitrequest;
        m1_readdata    = s_readdata;
        if (timeout_hit) begin
          m1_waitrequest = 1'b0;
          m1_readdata    = ABORT_DATA;
        end
      end
      default: ;
    endcase
    // Reset mid-transfer must never leak a partial write.
    if (!reset) begin
      s_read         = 1'b0;
      s_write        = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed scoreboard bench for mips_avalon_arbiter.
// Slave model with programmable wait states or a permanent stall.
module tb_mips_avalon_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m1_read;
  logic        m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address;
  logic [3:0]  s_byteenable;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        bus_timeout;

  int checks = 0;
  int errors = 0;

  mips_avalon_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_address     (m0_address),
    .m0_byteenable  (m0_byteenable),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_writedata   (m0_writedata),
    .m0_waitrequest (m0_waitrequest),
    .m0_readdata    (m0_readdata),
    .m1_address     (m1_address),
    .m1_byteenable  (m1_byteenable),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_writedata   (m1_writedata),
    .m1_waitrequest (m1_waitrequest),
    .m1_readdata    (m1_readdata),
    .s_address      (s_address),
    .s_byteenable   (s_byteenable),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_writedata    (s_writedata),
    .s_waitrequest  (s_waitrequest),
    .s_readdata     (s_readdata),
    .bus_timeout    (bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model
  int   rd_delay = 0;
  logic stuck = 1'b0;
  int   wcnt = 0;

  function automatic logic [31:0] model(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  assign s_waitrequest = stuck |
    ((s_read | s_write) && (wcnt < rd_delay));
  assign s_readdata = model(s_address);

  always_ff @(posedge clk) begin
    if (!(s_read | s_write) || !s_waitrequest) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp_v);
    end
  endtask

  task automatic push(input int m, input logic [31:0] a,
                      input logic wr, input logic [31:0] wd,
                      input logic [3:0] be);
    exp_t e;
    e.m = m; e.addr = a; e.wr = wr; e.wd = wd; e.be = be;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int id, input logic rd,
                       input logic wr, input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [3:0] be);
    if (id == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a;
      m0_writedata = wd; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a;
      m1_writedata = wd; m1_byteenable = be;
    end
  endtask

  task automatic idle(input int id);
    drive(id, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a slave-side completion, scores it, returns
  // the master seen and the number of negedges waited.
  task automatic wait_xfer(output int m, output int n);
    exp_t e;
    m = -1;
    n = 0;
    for (int i = 0; i < 64 && m < 0; i++) begin
      @(negedge clk);
      n++;
      if ((s_read || s_write) && !s_waitrequest) begin
        m = !m0_waitrequest ? 0 : 1;
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_master", m, e.m);
          chk("sb_addr", s_address, e.addr);
          chk("sb_rw", {s_read, s_write}, {~e.wr, e.wr});
          chk("sb_be", s_byteenable, e.be);
          if (e.wr) chk("sb_wdata", s_writedata, e.wd);
          else chk("sb_rdata",
                   m == 0 ? m0_readdata : m1_readdata,
                   model(e.addr));
          chk("sb_other_wait",
              m == 0 ? m1_waitrequest : m0_waitrequest, 1);
          chk("sb_other_rdata",
              m == 0 ? m1_readdata : m0_readdata, 0);
        end
      end
    end
    if (m < 0) chk("xfer_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int m, n;
    int k0, k1;
    reset = 1'b0;
    idle(0);
    idle(1);
    tick();
    tick();

    // Reset values
    @(negedge clk);
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_s_addr", s_address, 0);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_m0_rdata", m0_readdata, 0);
    chk("rst_m1_rdata", m1_readdata, 0);
    chk("rst_timeout", bus_timeout, 0);
    tick();
    reset = 1'b1;
    tick();

    // M1 boot fetch with two slave wait states
    rd_delay = 2;
    drive(1, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF);
    push(1, 32'hBFC0_0000, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    chk("t1_idle_sread", s_read, 0);
    chk("t1_idle_m1_wait", m1_waitrequest, 1);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk("t1_sread", s_read, 1);
      chk("t1_m1_wait", m1_waitrequest, 1);
      chk("t1_m0_wait", m0_waitrequest, 1);
    end
    wait_xfer(m, n);
    chk("t1_master", m, 1);
    chk("t1_lat", n, 1);
    idle(1);
    rd_delay = 0;
    tick();

    // Simultaneous M0 write / M1 read
    drive(0, 1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011);
    drive(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
    push(0, 32'h0000_0100, 1'b1, 32'h1234_5678, 4'b0011);
    push(1, 32'h0000_0200, 1'b0, 32'h0, 4'hF);
    wait_xfer(m, n);
    chk("t2_first", m, 0);
    chk("t2_lat0", n, 2);
    idle(0);
    wait_xfer(m, n);
    chk("t2_second", m, 1);
    chk("t2_lat1", n, 2);
    idle(1);
    tick();

    // Both masters continuously requesting
    k0 = 0;
    k1 = 0;
    drive(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
`ifdef ARB_ROUND_ROBIN_EN
    push(0, 32'h0000_1000, 1'b0, 32'h0, 4'hF);
    push(1, 32'h0000_2000, 1'b0, 32'h0, 4'hF);
    push(0, 32'h0000_1004, 1'b0, 32'h0, 4'hF);
    push(1, 32'h0000_2004, 1'b0, 32'h0, 4'hF);
`else
    push(0, 32'h0000_1000, 1'b0, 32'h0, 4'hF);
    push(0, 32'h0000_1004, 1'b0, 32'h0, 4'hF);
    push(0, 32'h0000_1008, 1'b0, 32'h0, 4'hF);
    push(0, 32'h0000_100C, 1'b0, 32'h0, 4'hF);
`endif
    for (int i = 0; i < 4; i++) begin
      wait_xfer(m, n);
      chk("t3_lat", n, 2);
      if (m == 0) begin
        k0++;
        drive(0, 1'b1, 1'b0, 32'h0000_1000 + 32'(4 * k0),
              32'h0, 4'hF);
      end else begin
        k1++;
        drive(1, 1'b1, 1'b0, 32'h0000_2000 + 32'(4 * k1),
              32'h0, 4'hF);
      end
    end
    idle(0);
    idle(1);
    chk("t3_sb_drained", exp_q.size(), 0);
    tick();

    // Read and write together: treated as write
    drive(0, 1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'hF);
    push(0, 32'h0000_0300, 1'b1, 32'hCAFE_F00D, 4'hF);
    wait_xfer(m, n);
    chk("t4_master", m, 0);
    idle(0);
    tick();

    // Watchdog with a permanently stalled slave
    stuck = 1'b1;
    chk("t5_pre_timeout", bus_timeout, 0);
    drive(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
    @(negedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("t5_stall_wait", m0_waitrequest, 1);
      chk("t5_stall_sread", s_read, 1);
    end
    @(negedge clk);
    chk("t5_abort_wait", m0_waitrequest, 0);
    chk("t5_abort_rdata", m0_readdata, 32'hDEAD_BEEF);
    chk("t5_m1_wait", m1_waitrequest, 1);
    tick();
    idle(0);
    chk("t5_flag_set", bus_timeout, 1);
    stuck = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("t5_flag_sticky", bus_timeout, 1);

    // Reset asserted mid-write with the slave stalled
    stuck = 1'b1;
    drive(0, 1'b0, 1'b1, 32'h0000_0500, 32'h0BAD_0BAD, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("t6_pre_swrite", s_write, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_swrite", s_write, 0);
    chk("t6_rst_m0_wait", m0_waitrequest, 1);
    chk("t6_rst_m1_wait", m1_waitrequest, 1);
    tick();
    reset = 1'b1;
    idle(0);
    stuck = 1'b0;
    @(negedge clk);
    chk("t6_post_timeout", bus_timeout, 0);
    chk("t6_post_swrite", s_write, 0);
    tick();

    // First tie after reset goes to M0
    drive(0, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'hF);
    push(0, 32'h0000_0600, 1'b0, 32'h0, 4'hF);
    push(1, 32'h0000_0700, 1'b0, 32'h0, 4'hF);
    wait_xfer(m, n);
    chk("t6_tie_first", m, 0);
    idle(0);
    wait_xfer(m, n);
    chk("t6_tie_second", m, 1);
    idle(1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
